// File: rtl/ro_pkg.sv
// ---------------------------------------------------------------------------
// ro_pkg
// Shared definitions for the ADC row packer:
//   - one-hot packer state encoding (same style as the readout FSM)
//   - default header tag byte
//   - half-word / word widths
//   - row header assembly function
// ---------------------------------------------------------------------------
package ro_pkg;

    typedef enum logic [2:0] {
        P_IDLE = 3'b001,
        P_HDR  = 3'b010,
        P_DATA = 3'b100
    } ro_state_t;

    localparam logic [7:0] RO_HDR_TAG = 8'hA5;
    localparam int         RO_HALF_W  = 16;
    localparam int         RO_WORD_W  = 32;

    // Row header layout: tag byte, low byte of the frame counter, row index.
    function automatic logic [RO_WORD_W-1:0] ro_make_hdr(
        input logic [7:0]  tag,
        input logic [7:0]  frame_lo,
        input logic [15:0] row
    );
        return {tag, frame_lo, row};
    endfunction

endpackage

// File: rtl/ro_half_pack.sv
// ---------------------------------------------------------------------------
// ro_half_pack
// Packs zero-extended ADC samples two per 32-bit word.
// Even-indexed samples are parked in a hold register (low half); the next
// odd-indexed sample completes the word {sample, hold}. A final sample that
// lands on an even index is flushed on its own as {16'h0000, sample}.
// The emit/word outputs are combinational; the parent registers them.
//
// Ports:
//   i_clk     clock
//   i_rst     asynchronous active-high reset (clears hold and toggle)
//   i_clr     start of a row: the sample pushed in this cycle is index 0
//   i_push    a sample is presented on i_sample this cycle
//   i_last    the pushed sample is the final one of the row
//   i_sample  raw ADC sample (ADC_W bits)
//   o_emit    a complete word is available on o_word this cycle
//   o_word    packed 32-bit word
// ---------------------------------------------------------------------------
module ro_half_pack
    import ro_pkg::*;
#(
    parameter int ADC_W = 12
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic                 i_push,
    input  logic                 i_last,
    input  logic [ADC_W-1:0]     i_sample,
    output logic                 o_emit,
    output logic [RO_WORD_W-1:0] o_word
);

    logic [RO_HALF_W-1:0] w_samp16;
    logic [RO_HALF_W-1:0] r_hold;
    logic                 r_odd;
    logic                 w_odd;

    // Zero-extend the sample to a half word bit by bit.
    genvar gi;
    generate
        for (gi = 0; gi < RO_HALF_W; gi++) begin : g_zext
            if (gi < ADC_W) begin : g_bit
                assign w_samp16[gi] = i_sample[gi];
            end else begin : g_zero
                assign w_samp16[gi] = 1'b0;
            end
        end
    endgenerate

    // A row start forces the current sample to be treated as even, so any
    // leftover toggle state from an earlier row can never pair across rows.
    assign w_odd = i_clr ? 1'b0 : r_odd;

    always_comb begin
        o_emit = 1'b0;
        o_word = {w_samp16, r_hold};
        if (i_push) begin
            if (w_odd) begin
                o_emit = 1'b1;
            end else if (i_last) begin
                o_emit = 1'b1;
                o_word = {{RO_HALF_W{1'b0}}, w_samp16};
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold <= '0;
            r_odd  <= 1'b0;
        end else if (i_push) begin
            if (!w_odd) begin
                r_hold <= w_samp16;
            end
            // After a pair or a final flush the next sample is even again.
            r_odd <= ~w_odd & ~i_last;
        end else if (i_clr) begin
            r_odd <= 1'b0;
        end
    end

endmodule

// File: rtl/ro_adc_packer.sv
// ---------------------------------------------------------------------------
// ro_adc_packer
// Per-channel ADC row packer. After a frame_start trigger it emits, for each
// row, one header word followed by the row's samples packed two per word,
// and writes everything into the readout FIFO.
//
// Ports:
//   CLK            ADC output clock (all inputs already in this domain)
//   rst            asynchronous active-high reset
//   frame_start    one-cycle trigger; accepted only while idle
//   adc_dat        ADC sample
//   adc_dat_valid  sample qualifier
//   NUM_SAMP       samples per row (low 16 bits used, latched at trigger)
//   NUM_ROW        rows per frame  (low 16 bits used, latched at trigger)
//   fifo_full      FIFO full flag
//   fifo_din       packed word to the FIFO
//   fifo_wr        FIFO write strobe
//   busy           frame in progress
//   frame_done     pulse together with the last word of a frame
//   overflow       sticky: a write happened while the FIFO was full
//   frame_cnt      completed-frame counter (wraps)
// ---------------------------------------------------------------------------
module ro_adc_packer
    import ro_pkg::*;
#(
    parameter int         ADC_W   = 12,
    parameter logic [7:0] HDR_TAG = RO_HDR_TAG
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic [ADC_W-1:0]     adc_dat,
    input  logic                 adc_dat_valid,
    input  logic [31:0]          NUM_SAMP,
    input  logic [31:0]          NUM_ROW,
    input  logic                 fifo_full,
    output logic [RO_WORD_W-1:0] fifo_din,
    output logic                 fifo_wr,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overflow,
    output logic [15:0]          frame_cnt
);

    ro_state_t r_state;
    ro_state_t w_state_next;

    logic [15:0]          r_num_samp;
    logic [15:0]          r_num_row;
    logic [15:0]          r_row_cnt;
    logic [15:0]          r_samp_cnt;
    logic [RO_WORD_W-1:0] r_fifo_din;
    logic                 r_fifo_wr;
    logic                 r_busy;
    logic                 r_frame_done;
    logic                 r_overflow;
    logic [15:0]          r_frame_cnt;

    logic                 w_accept;
    logic                 w_hdr_wr;
    logic                 w_push;
    logic                 w_last;
    logic                 w_row_end;
    logic                 w_frame_end;
    logic                 w_emit;
    logic [RO_WORD_W-1:0] w_word;

    // Only the low halves of the size inputs take part in the comparisons.
    logic w_unused_hi;
    assign w_unused_hi = ^{NUM_SAMP[31:16], NUM_ROW[31:16]};

    // ------------------------------------------------------------------
    // Next-state and per-cycle strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_hdr_wr     = 1'b0;
        w_push       = 1'b0;
        w_last       = 1'b0;
        w_row_end    = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            P_IDLE: begin
                if (frame_start) begin
                    w_accept     = 1'b1;
                    w_state_next = P_HDR;
                end
            end
            P_HDR: begin
                // Header goes out next cycle; a sample here is index 0 and
                // can never be the last one because a row has >= 2 samples.
                w_hdr_wr     = 1'b1;
                w_push       = adc_dat_valid;
                w_state_next = P_DATA;
            end
            P_DATA: begin
                if (adc_dat_valid) begin
                    w_push = 1'b1;
                    w_last = (r_samp_cnt == (r_num_samp - 16'd1));
                    if (w_last) begin
                        w_row_end = 1'b1;
                        if (r_row_cnt == (r_num_row - 16'd1)) begin
                            w_frame_end  = 1'b1;
                            w_state_next = P_IDLE;
                        end else begin
                            w_state_next = P_HDR;
                        end
                    end
                end
            end
            default: begin
                w_state_next = P_IDLE;
            end
        endcase
    end

    ro_half_pack #(
        .ADC_W (ADC_W)
    ) u_half_pack (
        .i_clk    (CLK),
        .i_rst    (rst),
        .i_clr    (w_hdr_wr),
        .i_push   (w_push),
        .i_last   (w_last),
        .i_sample (adc_dat),
        .o_emit   (w_emit),
        .o_word   (w_word)
    );

    // ------------------------------------------------------------------
    // State, counters and registered FIFO interface
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state      <= P_IDLE;
            r_num_samp   <= '0;
            r_num_row    <= '0;
            r_row_cnt    <= '0;
            r_samp_cnt   <= '0;
            r_fifo_din   <= '0;
            r_fifo_wr    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_frame_done <= w_frame_end;
            // Header and data cycles are mutually exclusive, so at most one
            // write per cycle.
            r_fifo_wr    <= w_hdr_wr | w_emit;

            if (w_hdr_wr) begin
                r_fifo_din <= ro_make_hdr(HDR_TAG, r_frame_cnt[7:0], r_row_cnt);
            end else if (w_emit) begin
                r_fifo_din <= w_word;
            end

            if (w_accept) begin
                r_num_samp <= NUM_SAMP[15:0];
                r_num_row  <= NUM_ROW[15:0];
                r_row_cnt  <= '0;
                r_busy     <= 1'b1;
            end

            if (w_hdr_wr) begin
                r_samp_cnt <= w_push ? 16'd1 : 16'd0;
            end else if (w_push) begin
                r_samp_cnt <= r_samp_cnt + 16'd1;
            end

            if (w_row_end && !w_frame_end) begin
                r_row_cnt <= r_row_cnt + 16'd1;
            end

            if (w_frame_end) begin
                r_busy      <= 1'b0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end

            // The word is still presented when the FIFO is full; the FIFO
            // drops it and we only remember that it happened. A write seen
            // in the same cycle as a new trigger keeps the flag set.
            if (r_fifo_wr && fifo_full) begin
                r_overflow <= 1'b1;
            end else if (w_accept) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign fifo_din   = r_fifo_din;
    assign fifo_wr    = r_fifo_wr;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign frame_cnt  = r_frame_cnt;

endmodule
